// File: rtl/spmm_csr_feeder.sv
// Dense-to-CSR LHS feeder: loads an NxN matrix one row per beat, compacting
// nonzeros into a flat {col,data} buffer, then streams them N lanes per beat.
module spmm_csr_feeder #(
  parameter int N     = 16,
  parameter int W     = 8,
  parameter int LGN   = $clog2(N),
  parameter int DBLGN = 2 * $clog2(N)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               mat_valid,
  output logic               mat_ready,
  input  logic [N*W-1:0]     mat_row,
  input  logic               lhs_ready_ns,
  output logic               lhs_start,
  output logic [N*DBLGN-1:0] lhs_ptr,
  output logic [N*LGN-1:0]   lhs_col,
  output logic [N*W-1:0]     lhs_data,
  output logic [DBLGN:0]     nnz,
  output logic               frame_done,
  output logic               dbg_state
);

  // Handshakes: a row moves on a clock edge where mat_valid && mat_ready; a
  // beat moves where lhs_start && lhs_ready_ns. Valid never waits on ready,
  // and an offered beat holds its contents until it is taken.
  typedef enum logic {S_LOAD = 1'b0, S_SEND = 1'b1} state_t;

  localparam logic [DBLGN:0]   C_N   = (DBLGN+1)'(N);
  localparam logic [DBLGN-1:0] C_ONE = DBLGN'(1);

  state_t           r_state;
  logic [LGN-1:0]   r_row_cnt;
  logic [LGN-1:0]   r_beat_cnt;
  logic [DBLGN:0]   r_nnz;
  logic [DBLGN-1:0] r_ptr [N];
  logic             r_frame_done;
  logic [LGN-1:0]   r_buf_col  [N*N];
  logic [W-1:0]     r_buf_data [N*N];

  logic [N-1:0]     w_nz;
  logic [LGN:0]     w_pos [N];
  logic [LGN:0]     w_row_nnz;
  logic [DBLGN:0]   w_base;
  logic [DBLGN:0]   w_nnz_new;
  logic [DBLGN-1:0] w_wr_idx [N];
  logic [DBLGN-1:0] w_rd_idx [N];
  logic             w_row_fire;
  logic             w_send;
  logic             w_last_beat;

  // Prefix popcount: each nonzero's slot is the number of nonzeros left of it.
  always_comb begin
    w_nz      = '0;
    w_pos     = '{default: '0};
    w_row_nnz = '0;
    for (int j = 0; j < N; j++) begin
      w_nz[j]   = (mat_row[j*W +: W] != '0);
      w_pos[j]  = w_row_nnz;
      w_row_nnz = w_row_nnz + {{LGN{1'b0}}, w_nz[j]};
    end
  end

  // Row 0 always starts at slot 0, so the last frame's count can stay visible.
  assign w_base     = (r_row_cnt == '0) ? '0 : r_nnz;
  assign w_nnz_new  = w_base + {{(DBLGN-LGN){1'b0}}, w_row_nnz};
  assign w_row_fire = !reset && (r_state == S_LOAD) && mat_valid;
  assign w_send     = !reset && (r_state == S_SEND);
  assign w_last_beat = ({1'b0, r_beat_cnt, {LGN{1'b0}}} + C_N) >= r_nnz;

  always_comb begin
    for (int j = 0; j < N; j++) begin
      w_wr_idx[j] = w_base[DBLGN-1:0] + {{(DBLGN-LGN-1){1'b0}}, w_pos[j]};
      w_rd_idx[j] = {r_beat_cnt, LGN'(j)};
    end
  end

  always_ff @(posedge clock) begin
    if (w_row_fire) begin
      for (int j = 0; j < N; j++) begin
        if (w_nz[j]) begin
          r_buf_col[w_wr_idx[j]]  <= LGN'(j);
          r_buf_data[w_wr_idx[j]] <= mat_row[j*W +: W];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_LOAD;
      r_row_cnt    <= '0;
      r_beat_cnt   <= '0;
      r_nnz        <= '0;
      r_ptr        <= '{default: '0};
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (mat_valid) begin
            r_ptr[r_row_cnt] <= w_nnz_new[DBLGN-1:0] - C_ONE;
            r_nnz            <= w_nnz_new;
            r_row_cnt        <= r_row_cnt + 1'b1;
            if (r_row_cnt == LGN'(N-1)) begin
              r_state    <= S_SEND;
              r_beat_cnt <= '0;
            end
          end
        end
        S_SEND: begin
          if (lhs_ready_ns) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            if (w_last_beat) begin
              r_state      <= S_LOAD;
              r_frame_done <= 1'b1;
              r_row_cnt    <= '0;
              r_beat_cnt   <= '0;
              r_ptr        <= '{default: '0};
            end
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  // Lanes past the frame's nonzero count are padded with zeros.
  always_comb begin
    lhs_col  = '0;
    lhs_data = '0;
    lhs_ptr  = '0;
    for (int i = 0; i < N; i++) begin
      if (w_send && ({1'b0, w_rd_idx[i]} < r_nnz)) begin
        lhs_col[i*LGN +: LGN] = r_buf_col[w_rd_idx[i]];
        lhs_data[i*W +: W]    = r_buf_data[w_rd_idx[i]];
      end
      if (w_send) lhs_ptr[i*DBLGN +: DBLGN] = r_ptr[i];
    end
  end

  assign mat_ready  = !reset && (r_state == S_LOAD);
  assign lhs_start  = w_send;
  assign frame_done = !reset && r_frame_done;
  assign nnz        = (w_send || frame_done) ? r_nnz : '0;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_spmm_csr_feeder.sv
// Bench for spmm_csr_feeder: random and directed matrices, compared against a
// row-major nonzero list built directly from the matrix.
module tb_spmm_csr_feeder;
  localparam int N = 16;
  localparam int W = 8;
  localparam int LGN = 4;
  localparam int DBLGN = 8;

  logic               clock = 1'b0;
  logic               reset;
  logic               mat_valid;
  logic               mat_ready;
  logic [N*W-1:0]     mat_row;
  logic               lhs_ready_ns;
  logic               lhs_start;
  logic [N*DBLGN-1:0] lhs_ptr;
  logic [N*LGN-1:0]   lhs_col;
  logic [N*W-1:0]     lhs_data;
  logic [DBLGN:0]     nnz;
  logic               frame_done;
  logic               dbg_state;

  spmm_csr_feeder #(.N(N), .W(W)) dut (
    .clock(clock), .reset(reset), .mat_valid(mat_valid), .mat_ready(mat_ready),
    .mat_row(mat_row), .lhs_ready_ns(lhs_ready_ns), .lhs_start(lhs_start),
    .lhs_ptr(lhs_ptr), .lhs_col(lhs_col), .lhs_data(lhs_data), .nnz(nnz),
    .frame_done(frame_done), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail = 0;

  logic [W-1:0]     m [N][N];
  logic [LGN+W-1:0] exp_q[$];
  logic [DBLGN-1:0] exp_ptr [N];
  int               exp_nnz;
  int               exp_b;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // matrix patterns: 0 identity, 1 all ones, 2 all zero, 3 sparse row 1, 4 random
  task automatic fill(input int kind);
    int p;
    p = $urandom_range(0, 100);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        case (kind)
          0: m[r][c] = (r == c) ? 8'd1 : 8'd0;
          1: m[r][c] = 8'd1;
          2: m[r][c] = 8'd0;
          3: m[r][c] = 8'd0;
          default: m[r][c] = ($urandom_range(0, 99) < p) ? W'($urandom_range(1, 255)) : 8'd0;
        endcase
      end
    if (kind == 3) begin
      m[1][2] = 8'd7;
      m[1][5] = 8'd8;
      m[1][9] = 8'd9;
    end
  endtask

  // reference: nonzeros in row-major order; ptr[r] is the running count minus one
  task automatic build_model();
    int cnt;
    cnt = 0;
    exp_q.delete();
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++)
        if (m[r][c] != 0) begin
          exp_q.push_back({LGN'(c), m[r][c]});
          cnt++;
        end
      exp_ptr[r] = DBLGN'(cnt - 1);
    end
    exp_nnz = cnt;
    exp_b = (cnt == 0) ? 1 : (cnt + N - 1) / N;
  endtask

  function automatic logic [N*W-1:0] row_vec(input int r);
    logic [N*W-1:0] v;
    for (int c = 0; c < N; c++) v[c*W +: W] = m[r][c];
    return v;
  endfunction

  task automatic load_matrix();
    for (int r = 0; r < N; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        mat_valid = 1'b0;
        mat_row = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clock);
      end
      chk($sformatf("row%0d_mat_ready", r), mat_ready, 1);
      mat_valid = 1'b1;
      mat_row = row_vec(r);
      @(negedge clock);
    end
    mat_valid = 1'b0;
  endtask

  task automatic drain(input int stall_beat, input int stall_len, input bit rand_rdy,
                       input bit hold_valid, input int abort_beat);
    int beats, cyc, stalled;
    bit rdy, prev_stall;
    logic [N*LGN-1:0]   e_col, p_col;
    logic [N*W-1:0]     e_data, p_data;
    logic [N*DBLGN-1:0] e_ptr;
    beats = 0; cyc = 0; stalled = 0; prev_stall = 0;
    p_col = '0; p_data = '0;
    for (int r = 0; r < N; r++) e_ptr[r*DBLGN +: DBLGN] = exp_ptr[r];
    while (beats < exp_b) begin
      if (cyc > 400) begin
        chk("drain_timeout", 1, 0);
        break;
      end
      if (beats == abort_beat) return;
      e_col = '0;
      e_data = '0;
      for (int i = 0; i < N; i++)
        if (i < exp_q.size()) begin
          e_col[i*LGN +: LGN] = exp_q[i][LGN+W-1:W];
          e_data[i*W +: W] = exp_q[i][W-1:0];
        end
      chk($sformatf("beat%0d_start", beats), lhs_start, 1);
      chk($sformatf("beat%0d_mat_ready", beats), mat_ready, 0);
      chk($sformatf("beat%0d_ptr", beats), lhs_ptr, e_ptr);
      chk($sformatf("beat%0d_nnz", beats), nnz, exp_nnz);
      chk($sformatf("beat%0d_col", beats), lhs_col, e_col);
      chk($sformatf("beat%0d_data", beats), lhs_data, e_data);
      chk($sformatf("beat%0d_frame_done", beats), frame_done, 0);
      if (prev_stall) begin
        chk($sformatf("beat%0d_hold_col", beats), lhs_col, p_col);
        chk($sformatf("beat%0d_hold_data", beats), lhs_data, p_data);
      end
      if (beats == stall_beat && stalled < stall_len) begin
        rdy = 1'b0;
        stalled++;
      end else if (rand_rdy) rdy = ($urandom_range(0, 3) != 0);
      else rdy = 1'b1;
      mat_valid = hold_valid;
      if (hold_valid) mat_row = {$urandom, $urandom, $urandom, $urandom} | {N{8'h01}};
      lhs_ready_ns = rdy;
      prev_stall = !rdy;
      p_col = lhs_col;
      p_data = lhs_data;
      @(negedge clock);
      cyc++;
      if (rdy) begin
        beats++;
        repeat (N) if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
    lhs_ready_ns = 1'b0;
    mat_valid = 1'b0;
    chk("end_frame_done", frame_done, 1);
    chk("end_nnz_held", nnz, exp_nnz);
    chk("end_lhs_start", lhs_start, 0);
    chk("end_mat_ready", mat_ready, 1);
    chk("end_lhs_ptr", lhs_ptr, 0);
    chk("end_lhs_data", lhs_data, 0);
    @(negedge clock);
    chk("post_frame_done", frame_done, 0);
    chk("post_nnz", nnz, 0);
  endtask

  task automatic run_frame(input int kind, input int stall_beat, input int stall_len,
                           input bit rand_rdy, input bit hold_valid);
    fill(kind);
    build_model();
    load_matrix();
    drain(stall_beat, stall_len, rand_rdy, hold_valid, -1);
  endtask

  task automatic reset_checks(input string tag);
    #1;
    chk({tag, "_rst_mat_ready"}, mat_ready, 0);
    chk({tag, "_rst_lhs_start"}, lhs_start, 0);
    chk({tag, "_rst_lhs_col"}, lhs_col, 0);
    chk({tag, "_rst_lhs_data"}, lhs_data, 0);
    chk({tag, "_rst_lhs_ptr"}, lhs_ptr, 0);
    chk({tag, "_rst_frame_done"}, frame_done, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk({tag, "_post_mat_ready"}, mat_ready, 1);
    chk({tag, "_post_lhs_start"}, lhs_start, 0);
    chk({tag, "_post_nnz"}, nnz, 0);
    chk({tag, "_post_frame_done"}, frame_done, 0);
    @(negedge clock);
    chk({tag, "_post2_frame_done"}, frame_done, 0);
  endtask

  initial begin
    reset = 1'b1;
    mat_valid = 1'b0;
    lhs_ready_ns = 1'b0;
    mat_row = '0;
    repeat (3) @(negedge clock);
    reset_checks("init");

    run_frame(0, -1, 0, 1'b0, 1'b0);
    run_frame(1, -1, 0, 1'b0, 1'b0);
    run_frame(2, -1, 0, 1'b0, 1'b0);
    run_frame(3, -1, 0, 1'b0, 1'b0);
    run_frame(1, 3, 5, 1'b0, 1'b0);

    // abort a frame with reset while beat 2 is on offer
    fill(1);
    build_model();
    load_matrix();
    drain(-1, 0, 1'b0, 1'b0, 2);
    reset = 1'b1;
    lhs_ready_ns = 1'b0;
    mat_valid = 1'b0;
    reset_checks("abort");
    run_frame(0, -1, 0, 1'b0, 1'b0);

    run_frame(1, -1, 0, 1'b0, 1'b1);
    repeat (6) run_frame(4, -1, 0, 1'b1, 1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
